// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// Latency: none, wires only.
// Backpressure: mem_ready from the memory side stretches memory states.
// Ports: op/funct/zero/mem_ready flow datapath -> controller; every select,
//        enable, illegal_op and state_dbg flow controller -> datapath.
interface mips_multicycle_ctrl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_en;
   logic       iord;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_src;
   logic [2:0] alu_control;
   logic       illegal_op;
   logic [3:0] state_dbg;

   // Controller side
   modport master (
      input  op, funct, zero, mem_ready,
      output pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, state_dbg
   );

   // Datapath side
   modport slave (
      output op, funct, zero, mem_ready,
      input  pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, state_dbg
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath.
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles; each mem_ready=0 cycle adds one.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready=1.
// Ports: clk, rst (sync, active-low); ctrl_if.master carries op/funct/zero/
//        mem_ready in and all datapath selects/enables, illegal_op, state_dbg out.
module mips_multicycle_ctrl #(
   parameter bit ILLEGAL_TRAP = 1'b1
) (
   input logic                    clk,
   input logic                    rst,
   mips_multicycle_ctrl_if.master ctrl_if
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_ERROR  = 4'd15
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t state_q, state_d;
   // MEMADR must choose lw vs sw without looking at op again, so DECODE
   // remembers which one it saw.
   logic   is_lw_q, is_lw_d;

   logic       funct_ok;
   logic [2:0] funct_alu;
   logic       op_illegal;
   state_t     out_state;
   logic       pc_write;
   logic       branch;

   // Funct decode, used for legality in DECODE and ALU selection in EXEC
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (ctrl_if.funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         default: funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      op_illegal = 1'b0;
      case (ctrl_if.op)
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_illegal = 1'b0;
         OP_R:    op_illegal = !funct_ok;
         default: op_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
         is_lw_q <= 1'b0;
      end else begin
         state_q <= state_d;
         is_lw_q <= is_lw_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      is_lw_d = is_lw_q;
      case (state_q)
         S_FETCH:  if (ctrl_if.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (op_illegal) begin
               state_d = ILLEGAL_TRAP ? S_ERROR : S_FETCH;
            end else begin
               case (ctrl_if.op)
                  OP_LW: begin
                     state_d = S_MEMADR;
                     is_lw_d = 1'b1;
                  end
                  OP_SW: begin
                     state_d = S_MEMADR;
                     is_lw_d = 1'b0;
                  end
                  OP_R:    state_d = S_EXEC;
                  OP_BEQ:  state_d = S_BRANCH;
                  OP_ADDI: state_d = S_ADDIEX;
                  OP_J:    state_d = S_JUMP;
                  default: state_d = S_FETCH;
               endcase
            end
         end
         S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (ctrl_if.mem_ready) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (ctrl_if.mem_ready) state_d = S_FETCH;
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_ERROR:  state_d = S_ERROR;
         default:  state_d = S_FETCH;
      endcase
   end

   // Outputs. While reset is held the selects present FETCH values even if
   // the register has not yet been reloaded, and all enables are forced low.
   always_comb begin
      out_state           = rst ? state_q : S_FETCH;
      pc_write            = 1'b0;
      branch              = 1'b0;
      ctrl_if.iord        = 1'b0;
      ctrl_if.mem_write   = 1'b0;
      ctrl_if.ir_write    = 1'b0;
      ctrl_if.reg_write   = 1'b0;
      ctrl_if.reg_dst     = 1'b0;
      ctrl_if.mem_to_reg  = 1'b0;
      ctrl_if.alu_src_a   = 1'b0;
      ctrl_if.alu_src_b   = 2'b00;
      ctrl_if.pc_src      = 2'b00;
      ctrl_if.alu_control = ALU_ADD;
      ctrl_if.illegal_op  = 1'b0;
      case (out_state)
         S_FETCH: begin
            ctrl_if.alu_src_b = 2'b01;
            ctrl_if.ir_write  = ctrl_if.mem_ready;
            pc_write          = ctrl_if.mem_ready;
         end
         S_DECODE: begin
            ctrl_if.alu_src_b  = 2'b11;
            ctrl_if.illegal_op = op_illegal && !ILLEGAL_TRAP;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl_if.alu_src_a = 1'b1;
            ctrl_if.alu_src_b = 2'b10;
         end
         S_MEMRD: ctrl_if.iord = 1'b1;
         S_MEMWB: begin
            ctrl_if.mem_to_reg = 1'b1;
            ctrl_if.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            ctrl_if.iord      = 1'b1;
            ctrl_if.mem_write = 1'b1;
         end
         S_EXEC: begin
            ctrl_if.alu_src_a   = 1'b1;
            ctrl_if.alu_control = funct_alu;
         end
         S_ALUWB: begin
            ctrl_if.reg_dst   = 1'b1;
            ctrl_if.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl_if.alu_src_a   = 1'b1;
            ctrl_if.alu_control = ALU_SUB;
            ctrl_if.pc_src      = 2'b01;
            branch              = 1'b1;
         end
         S_ADDIWB: ctrl_if.reg_write = 1'b1;
         S_JUMP: begin
            ctrl_if.pc_src = 2'b10;
            pc_write       = 1'b1;
         end
         S_ERROR: ctrl_if.illegal_op = 1'b1;
         default: ;
      endcase
      ctrl_if.pc_en = pc_write | (branch & ctrl_if.zero);
      if (!rst) begin
         ctrl_if.pc_en      = 1'b0;
         ctrl_if.mem_write  = 1'b0;
         ctrl_if.ir_write   = 1'b0;
         ctrl_if.reg_write  = 1'b0;
         ctrl_if.illegal_op = 1'b0;
      end
   end

   assign ctrl_if.state_dbg = state_q;

endmodule
